band_gain_mixer: RTL and testbench

Equalizer gain-and-sum stage that sits directly downstream of fir_all_filters. It consumes the ten 24-bit band outputs (low-pass, eight band-pass, high-pass) and applies a programmable signed gain to each band. The weighted bands are summed into one 24-bit equalized output sample. A single time-multiplexed multiplier-accumulator handles all ten bands, controlled by a small FSM; a register write port loads the per-band gains.

---
 rtl/band_gain_mixer.sv | 168 ++++++++++++++++
 tb/tb_band_gain_mixer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/band_gain_mixer.sv
// rtl/band_gain_mixer.sv - ten-band programmable gain and sum stage with a shared MAC
module band_gain_mixer #(
    parameter int DATA_W    = 24,
    parameter int GAIN_W    = 16,
    parameter int GAIN_FRAC = 14,
    parameter int ACC_W     = 44
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] band_in_0,
    input  logic [DATA_W-1:0] band_in_1,
    input  logic [DATA_W-1:0] band_in_2,
    input  logic [DATA_W-1:0] band_in_3,
    input  logic [DATA_W-1:0] band_in_4,
    input  logic [DATA_W-1:0] band_in_5,
    input  logic [DATA_W-1:0] band_in_6,
    input  logic [DATA_W-1:0] band_in_7,
    input  logic [DATA_W-1:0] band_in_8,
    input  logic [DATA_W-1:0] band_in_9,
    input  logic              gain_wr_en,
    input  logic [3:0]        gain_addr,
    input  logic [GAIN_W-1:0] gain_data,
    output logic [DATA_W-1:0] output_sample,
    output logic              output_valid,
    output logic              busy,
    output logic              clip,
    output logic              overrun
);

    localparam int NBANDS = 10;
    localparam int PROD_W = DATA_W + GAIN_W;

    localparam logic signed [GAIN_W-1:0] UNITY   = {{(GAIN_W-1){1'b0}}, 1'b1} << GAIN_FRAC;
    localparam logic signed [ACC_W-1:0]  RND     = {{(ACC_W-1){1'b0}}, 1'b1} << (GAIN_FRAC-1);
    localparam logic signed [ACC_W-1:0]  SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0]  SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_OUTPUT
    } state_t;

    state_t state, state_nxt;

    logic signed [DATA_W-1:0] band_bus  [NBANDS];
    logic signed [DATA_W-1:0] band_q    [NBANDS];
    logic signed [GAIN_W-1:0] gain_reg  [NBANDS];
    logic signed [GAIN_W-1:0] gain_snap [NBANDS];
    logic [3:0]               idx;
    logic signed [ACC_W-1:0]  acc;

    logic                     capture;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_rnd;
    logic signed [ACC_W-1:0]  acc_shr;
    logic [DATA_W-1:0]        sat_val;
    logic                     sat_hit;

    assign band_bus[0] = band_in_0;
    assign band_bus[1] = band_in_1;
    assign band_bus[2] = band_in_2;
    assign band_bus[3] = band_in_3;
    assign band_bus[4] = band_in_4;
    assign band_bus[5] = band_in_5;
    assign band_bus[6] = band_in_6;
    assign band_bus[7] = band_in_7;
    assign band_bus[8] = band_in_8;
    assign band_bus[9] = band_in_9;

    assign capture = (state == S_IDLE) && enable && sample_valid;
    assign busy    = (state != S_IDLE);

    assign prod    = PROD_W'(band_q[idx]) * PROD_W'(gain_snap[idx]);
    // Round half toward +inf, then drop the Q2.14 fraction.
    assign acc_rnd = acc + RND;
    assign acc_shr = acc_rnd >>> GAIN_FRAC;

    always_comb begin
        sat_val = acc_shr[DATA_W-1:0];
        sat_hit = 1'b0;
        if (acc_shr > SAT_MAX) begin
            sat_val = SAT_MAX[DATA_W-1:0];
            sat_hit = 1'b1;
        end else if (acc_shr < SAT_MIN) begin
            sat_val = SAT_MIN[DATA_W-1:0];
            sat_hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (capture) state_nxt = S_ACCUM;
            end
            S_ACCUM: begin
                if (!enable)                       state_nxt = S_IDLE;
                else if (idx == 4'(NBANDS - 1))    state_nxt = S_OUTPUT;
            end
            S_OUTPUT: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            output_sample <= '0;
            output_valid  <= 1'b0;
            clip          <= 1'b0;
            overrun       <= 1'b0;
            acc           <= '0;
            idx           <= '0;
            for (int i = 0; i < NBANDS; i++) begin
                gain_reg[i]  <= UNITY;
                gain_snap[i] <= UNITY;
                band_q[i]    <= '0;
            end
        end else begin
            output_valid <= 1'b0;
            clip         <= 1'b0;
            overrun      <= busy && sample_valid;

            if (gain_wr_en && (gain_addr < 4'(NBANDS))) begin
                gain_reg[gain_addr] <= gain_data;
            end

            case (state)
                S_IDLE: begin
                    if (capture) begin
                        // Snapshot reads gain_reg before any same-edge write lands.
                        for (int i = 0; i < NBANDS; i++) begin
                            band_q[i]    <= band_bus[i];
                            gain_snap[i] <= gain_reg[i];
                        end
                        acc <= '0;
                        idx <= '0;
                    end
                end
                S_ACCUM: begin
                    if (enable) begin
                        acc <= acc + ACC_W'(prod);
                        idx <= idx + 4'd1;
                    end
                end
                S_OUTPUT: begin
                    if (enable) begin
                        output_sample <= sat_val;
                        output_valid  <= 1'b1;
                        clip          <= sat_hit;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_band_gain_mixer.sv
// tb/tb_band_gain_mixer.sv - scoreboard bench for band_gain_mixer
module tb_band_gain_mixer;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               enable;
    logic               sample_valid;
    logic signed [23:0] band [10];
    logic               gain_wr_en;
    logic [3:0]         gain_addr;
    logic [15:0]        gain_data;
    logic signed [23:0] output_sample;
    logic               output_valid;
    logic               busy;
    logic               clip;
    logic               overrun;

    always #5 clk = ~clk;

    band_gain_mixer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .sample_valid  (sample_valid),
        .band_in_0     (band[0]),
        .band_in_1     (band[1]),
        .band_in_2     (band[2]),
        .band_in_3     (band[3]),
        .band_in_4     (band[4]),
        .band_in_5     (band[5]),
        .band_in_6     (band[6]),
        .band_in_7     (band[7]),
        .band_in_8     (band[8]),
        .band_in_9     (band[9]),
        .gain_wr_en    (gain_wr_en),
        .gain_addr     (gain_addr),
        .gain_data     (gain_data),
        .output_sample (output_sample),
        .output_valid  (output_valid),
        .busy          (busy),
        .clip          (clip),
        .overrun       (overrun)
    );

    typedef struct packed {
        logic signed [31:0] sample;
        logic               clip;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   mgain [10];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model();
        longint acc = 0;
        longint r;
        exp_t   e;
        for (int i = 0; i < 10; i++) acc += longint'(band[i]) * longint'(mgain[i]);
        r = (acc + 8192) >>> 14;
        if (r > 8388607) begin
            e.sample = 8388607;  e.clip = 1'b1;
        end else if (r < -8388608) begin
            e.sample = -8388608; e.clip = 1'b1;
        end else begin
            e.sample = int'(r);  e.clip = 1'b0;
        end
        return e;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_gain(input int a, input int v);
        gain_wr_en = 1'b1;
        gain_addr  = a[3:0];
        gain_data  = v[15:0];
        tick();
        gain_wr_en = 1'b0;
        if (a < 10) mgain[a] = v;
    endtask

    task automatic set_bands(input int v);
        for (int i = 0; i < 10; i++) band[i] = v[23:0];
    endtask

    task automatic start(input bit push);
        sample_valid = 1'b1;
        if (push) exp_q.push_back(model());
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int already);
        int   n = already;
        bit   seen = 1'b0;
        exp_t e;
        while (n < already + 25 && !seen) begin
            tick();
            n++;
            if (output_valid) seen = 1'b1;
        end
        chk({tag, "_seen"}, int'(seen), 1);
        chk({tag, "_latency"}, n, 11);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_sample"}, int'(output_sample), int'(e.sample));
            chk({tag, "_clip"}, int'(clip), int'(e.clip));
        end
    endtask

    task automatic watch_quiet(input string tag, input int cycles);
        bit any = 1'b0;
        repeat (cycles) begin
            tick();
            if (output_valid) any = 1'b1;
        end
        chk(tag, int'(any), 0);
    endtask

    initial begin
        reset_n      = 1'b0;
        enable       = 1'b1;
        sample_valid = 1'b0;
        gain_wr_en   = 1'b0;
        gain_addr    = '0;
        gain_data    = '0;
        set_bands(0);
        for (int i = 0; i < 10; i++) mgain[i] = 16384;
        tick();
        tick();
        chk("rst_sample",  int'(output_sample), 0);
        chk("rst_valid",   int'(output_valid), 0);
        chk("rst_busy",    int'(busy), 0);
        chk("rst_clip",    int'(clip), 0);
        chk("rst_overrun", int'(overrun), 0);
        reset_n = 1'b1;
        tick();

        set_bands(1000);
        start(1'b1);
        chk("busy_after_capture", int'(busy), 1);
        wait_out("unity", 0);
        tick();
        chk("valid_one_cycle", int'(output_valid), 0);
        chk("sample_holds", int'(output_sample), 10000);

        set_gain(0, 32767);
        for (int i = 1; i < 10; i++) set_gain(i, 0);
        set_bands(1234);
        band[0] = 24'sd8388607;
        start(1'b1);
        wait_out("sat_pos", 0);
        band[0] = -24'sd8388608;
        start(1'b1);
        wait_out("sat_neg", 0);

        set_gain(0, 0);
        set_gain(3, 8192);
        band[3] = 24'sd3;
        start(1'b1);
        wait_out("rnd_p3", 0);
        band[3] = -24'sd3;
        start(1'b1);
        wait_out("rnd_m3", 0);
        band[3] = 24'sd1;
        start(1'b1);
        wait_out("rnd_p1", 0);

        for (int i = 0; i < 10; i++) set_gain(i, 16384);
        set_gain(10, 0);
        set_bands(1000);
        start(1'b1);
        repeat (4) tick();
        sample_valid = 1'b1;
        set_bands(5);
        tick();
        sample_valid = 1'b0;
        chk("overrun_e5", int'(overrun), 1);
        tick();
        chk("overrun_e6", int'(overrun), 0);
        wait_out("ovr_first", 6);
        set_bands(200);
        start(1'b1);
        chk("no_overrun_e12", int'(overrun), 0);
        wait_out("back_to_back", 0);

        set_bands(100);
        start(1'b1);
        repeat (3) tick();
        gain_wr_en = 1'b1;
        gain_addr  = 4'd0;
        gain_data  = 16'd0;
        tick();
        gain_wr_en = 1'b0;
        mgain[0]   = 0;
        wait_out("gw_during", 4);
        start(1'b1);
        wait_out("gw_after", 0);

        gain_wr_en   = 1'b1;
        gain_addr    = 4'd1;
        gain_data    = 16'd0;
        sample_valid = 1'b1;
        exp_q.push_back(model());
        tick();
        gain_wr_en   = 1'b0;
        sample_valid = 1'b0;
        mgain[1]     = 0;
        wait_out("gw_same_edge", 0);
        start(1'b1);
        wait_out("gw_same_next", 0);

        set_gain(5, 0);
        set_bands(100);
        start(1'b0);
        repeat (5) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) mgain[i] = 16384;
        chk("abort_rst_busy", int'(busy), 0);
        chk("abort_rst_sample", int'(output_sample), 0);
        watch_quiet("abort_rst_quiet", 15);
        start(1'b1);
        wait_out("post_rst_unity", 0);

        set_gain(9, 0);
        set_bands(50);
        start(1'b0);
        repeat (5) tick();
        enable = 1'b0;
        tick();
        chk("abort_en_busy", int'(busy), 0);
        enable = 1'b1;
        watch_quiet("abort_en_quiet", 15);
        chk("abort_en_hold", int'(output_sample), 1000);

        enable       = 1'b0;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        chk("idle_dis_busy", int'(busy), 0);
        chk("idle_dis_overrun", int'(overrun), 0);
        tick();
        enable = 1'b1;
        watch_quiet("idle_dis_quiet", 13);

        set_bands(100);
        start(1'b1);
        wait_out("gains_kept", 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
